mul_div_unit: RTL

Multi-cycle 32-bit multiply/divide unit, a sequential consumer of the team's `cla32` carry-lookahead adder. It executes MIPS-style `multu`/`mult`/`divu`/`div` with one `cla32` add or subtract per iteration, and holds results in architectural HI/LO registers. It sits beside the ALU in the execute stage. The control unit stalls on `busy` and reads `hi`/`lo` for `mfhi`/`mflo`.

---
 rtl/mul_div_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle 32-bit multiply/divide unit (multu/mult/divu/div) with architectural HI/LO.
// All add/subtract work is routed through two shared cla32 carry-lookahead adders.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] sum,
  output logic        co
);
  logic [31:0] g, p;
  logic [7:0]  grp_g, grp_p;
  logic [8:0]  grp_c;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate over 4-bit blocks, lookahead across blocks.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;
    for (int k = 0; k < 8; k++) begin
      grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
                 (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
    grp_c[0] = ci;
    for (int k = 0; k < 8; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[32] = grp_c[8];
  end

  assign sum = p ^ c[31:0];
  assign co  = c[32];
endmodule

// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes accepted
// PREP  | take operand magnitudes for signed ops, record result signs
// RUN   | 32 shift-add or restoring-divide iterations
// FIX   | apply sign / divide-by-zero override, write HI/LO, pulse done
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt;
  logic [1:0]  op_r;
  logic [31:0] acc_hi, acc_lo, opnd, a_orig;
  logic        neg_q, neg_r;

  logic [31:0] add0_a, add0_b, add0_sum, add1_a, add1_b, add1_sum;
  logic        add0_ci, add0_co, add1_ci, add1_co_unused;
  logic [31:0] r_sh;
  logic        r_msb;

  assign r_sh  = {acc_hi[30:0], acc_lo[31]};
  assign r_msb = acc_hi[31];
  assign busy  = (state_q != IDLE);

  cla32 u_add0 (.a(add0_a), .b(add0_b), .ci(add0_ci), .sum(add0_sum), .co(add0_co));
  cla32 u_add1 (.a(add1_a), .b(add1_b), .ci(add1_ci), .sum(add1_sum), .co(add1_co_unused));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    add0_a  = '0;
    add0_b  = '0;
    add0_ci = 1'b0;
    add1_a  = '0;
    add1_b  = '0;
    add1_ci = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: begin
        state_d = RUN;
        add0_a  = ~acc_lo;
        add0_ci = 1'b1;
        add1_a  = ~opnd;
        add1_ci = 1'b1;
      end
      RUN: begin
        if (cnt == 5'd31) state_d = FIX;
        if (!op_r[1]) begin
          add0_a = acc_hi;
          add0_b = acc_lo[0] ? opnd : 32'd0;
        end else begin
          add0_a  = r_sh;
          add0_b  = ~opnd;
          add0_ci = 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        // Divide negates Q and R independently; multiply chains low carry into high half.
        add0_a  = ~acc_lo;
        add0_ci = 1'b1;
        add1_a  = ~acc_hi;
        add1_ci = op_r[1] ? 1'b1 : add0_co;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      op_r        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      a_orig      <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done <= (state_q == FIX);
      case (state_q)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_r        <= op;
            acc_lo      <= a;
            opnd        <= b;
            a_orig      <= a;
            div_by_zero <= op[1] & (b == 32'd0);
          end
        end
        PREP: begin
          acc_lo <= (op_r[0] & acc_lo[31]) ? add0_sum : acc_lo;
          opnd   <= (op_r[0] & opnd[31]) ? add1_sum : opnd;
          acc_hi <= '0;
          neg_q  <= op_r[0] & (acc_lo[31] ^ opnd[31]);
          neg_r  <= op_r[0] & acc_lo[31];
          cnt    <= '0;
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (!op_r[1]) begin
            acc_hi <= {add0_co, add0_sum[31:1]};
            acc_lo <= {add0_sum[0], acc_lo[31:1]};
          end else if (r_msb | add0_co) begin
            acc_hi <= add0_sum;
            acc_lo <= {acc_lo[30:0], 1'b1};
          end else begin
            acc_hi <= r_sh;
            acc_lo <= {acc_lo[30:0], 1'b0};
          end
        end
        FIX: begin
          if (op_r[1] && div_by_zero) begin
            hi <= a_orig;
            lo <= 32'hFFFF_FFFF;
          end else if (op_r == 2'b11) begin
            hi <= neg_r ? add1_sum : acc_hi;
            lo <= neg_q ? add0_sum : acc_lo;
          end else if (op_r == 2'b01 && neg_q) begin
            hi <= add1_sum;
            lo <= add0_sum;
          end else begin
            hi <= acc_hi;
            lo <= acc_lo;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
